// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle add/subtract: one 4-bit carry-lookahead stage is reused over the operand, LSB nibble first.
// Result is valid NIB cycles after start is accepted. start is ignored while busy.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg, b_reg, res, res_nxt;
  logic             carry;
  logic             accept, last;
  logic [3:0]       an, bn, p, g, nsum;
  logic             c0, c1, c2, c3;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (idx == IW'(NIB - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Flattened lookahead: every carry is a direct function of p, g and carry.
  always_comb begin
    an = a_reg[4*idx +: 4];
    bn = b_reg[4*idx +: 4];
    p  = an ^ bn;
    g  = an & bn;
    c0 = g[0] | (p[0] & carry);
    c1 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c2 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    c3 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & carry);
    nsum = p ^ {c2, c1, c0, carry};
    res_nxt = res;
    res_nxt[4*idx +: 4] = nsum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      res   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_reg <= a;
        b_reg <= sub ? ~b : b;
        carry <= sub;
        idx   <= '0;
      end
      if (state == RUN) begin
        res   <= res_nxt;
        carry <= c3;
        idx   <= idx + IW'(1);
        if (last) begin
          idx  <= '0;
          sum  <= res_nxt;
          cout <= c3;
          ovf  <= c2 ^ c3;
          zero <= (res_nxt == '0);
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (WIDTH=32): expected results queued at issue, compared at done.
module tb_nibble_serial_adder_ctrl;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf, zero;
  logic [W-1:0] sum;

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    res_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb     = sv ? ~bv : bv;
    full   = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, sv};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (av[W-1] == bb[W-1]) && (r.sum[W-1] != av[W-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; sub = sv;
    exp_q.push_back(model(av, bv, sv));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(inout int n);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf, zero} !== '0)
      $display("FAIL reset_state got busy=%b done=%b sum=%h cout=%b ovf=%b zero=%b want all 0",
               busy, done, sum, cout, ovf, zero);
    if ({busy, done, sum, cout, ovf, zero} !== '0) failures++;
    rst = 1'b0;
  endtask

  task automatic run_table(input string name, input logic [W-1:0] at[3], input logic [W-1:0] bt[3],
                           input logic st);
    for (int i = 0; i < 3; i++) begin
      int   n;
      res_t got, exp;
      issue(at[i], bt[i], st);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_busy[%0d] got %b want 1", name, i, busy);
      end
      n = 0;
      wait_done(n);
      checks++;
      if (n !== 8) begin
        failures++;
        $display("FAIL %s_latency[%0d] got %0d want 8", name, i, n);
      end
      got = '{sum, cout, ovf, zero};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s_result[%0d] got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                 name, i, got.sum, got.cout, got.ovf, got.zero, exp.sum, exp.cout, exp.ovf, exp.zero);
      end
    end
  endtask

  task automatic test_add;
    logic [W-1:0] at[3] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [W-1:0] bt[3] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001};
    run_table("add", at, bt, 1'b0);
  endtask

  task automatic test_sub;
    logic [W-1:0] at[3] = '{32'h0000_0005, 32'h0000_0003, 32'h8000_0000};
    logic [W-1:0] bt[3] = '{32'h0000_0005, 32'h0000_0005, 32'h0000_0001};
    run_table("sub", at, bt, 1'b1);
  endtask

  task automatic test_back_to_back;
    int   n;
    res_t got, exp;
    issue(32'd1, 32'd2, 1'b0);
    n = 0;
    @(negedge clk); n++;
    start = 1'b1; a = 32'd9; b = 32'd9; sub = 1'b0;
    @(negedge clk); n++;
    start = 1'b1; a = 32'd4; b = 32'd4;
    wait_done(n);
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL b2b_first_latency got %0d want 8", n);
    end
    got = '{sum, cout, ovf, zero};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL b2b_first_result got sum=%h want sum=%h", got.sum, exp.sum);
    end
    exp_q.push_back(model(32'd4, 32'd4, 1'b0));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, busy, sum} !== {1'b0, 1'b1, 32'd3}) begin
      failures++;
      $display("FAIL b2b_accept got done=%b busy=%b sum=%h want done=0 busy=1 sum=00000003",
               done, busy, sum);
    end
    n = 0;
    wait_done(n);
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL b2b_second_latency got %0d want 8", n);
    end
    got = '{sum, cout, ovf, zero};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL b2b_second_result got sum=%h want sum=%h", got.sum, exp.sum);
    end
  endtask

  task automatic test_reset_midop;
    int   n;
    int   pulses;
    res_t got, exp;
    @(negedge clk);
    start = 1'b1; a = 32'h10; b = 32'h20; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf, zero} !== '0) begin
      failures++;
      $display("FAIL midop_reset got busy=%b done=%b sum=%h cout=%b ovf=%b zero=%b want all 0",
               busy, done, sum, cout, ovf, zero);
    end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL midop_no_done got %0d pulses want 0", pulses);
    end
    issue(32'd1, 32'd1, 1'b0);
    n = 0;
    wait_done(n);
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL midop_fresh_latency got %0d want 8", n);
    end
    got = '{sum, cout, ovf, zero};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL midop_fresh_result got sum=%h want sum=%h", got.sum, exp.sum);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_back_to_back;
    test_reset_midop;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
